// File: rtl/mux_pkg.sv
// mux_pkg
// Shared definitions for channel_scan_mux and its scan_counter:
//   state_t    - controller states (IDLE, MANUAL, SCAN, STALL)
//   CNT_W      - width of the dwell counter, wide enough for DWELL up to 255
//   sel_width  - channel-select width for a given channel count, never below 1
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2,
    STALL  = 2'd3
  } state_t;

  localparam int CNT_W = 8;

  function automatic int sel_width(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// scan_counter
// Dwell counter plus wrapping channel pointer used by the auto-scan mode.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - restart the scan: counter and pointer to 0
//   adv       - a sample was taken: counter to 0, pointer to next channel
//   hold      - freeze counter and pointer
//   ch_ptr    - channel currently being dwelt on
//   term      - counter is at its terminal value DWELL-1
// Control priority is clr > adv > hold > count.
module scan_counter
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DWELL = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic             hold,
  output logic [SEL_W-1:0] ch_ptr,
  output logic             term
);

  logic [CNT_W-1:0] cnt;

  assign term = (cnt == CNT_W'(DWELL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      ch_ptr <= '0;
    end else if (clr) begin
      cnt    <= '0;
      ch_ptr <= '0;
    end else if (adv) begin
      cnt    <= '0;
      ch_ptr <= (ch_ptr == SEL_W'(N_CH - 1)) ? '0 : ch_ptr + SEL_W'(1);
    end else if (!hold) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/channel_scan_mux.sv
// channel_scan_mux
// Registered N_CH-to-1 channel multiplexer with a manual-select mode and an
// auto-scan mode that dwells DWELL cycles per channel, behind a valid/ready
// output handshake.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   en         - 1 = running, 0 = idle (outputs frozen, pending sample kept)
//   mode       - 0 = manual select via s, 1 = auto scan
//   w          - packed channel data, channel k at [k*W +: W]
//   s          - manual channel select
//   y, ch      - captured sample and the channel it came from
//   out_valid  - y/ch hold a sample not yet accepted
//   out_ready  - consumer accepts when out_valid && out_ready
//   sel_err    - one-cycle pulse after an out-of-range manual select is captured
module channel_scan_mux
  import mux_pkg::*;
#(
  parameter int  N_CH  = 4,
  parameter int  W     = 8,
  parameter int  DWELL = 4,
  localparam int SEL_W = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [N_CH*W-1:0] w,
  input  logic [SEL_W-1:0]  s,
  output logic [W-1:0]      y,
  output logic [SEL_W-1:0]  ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err
);

  state_t           state;
  logic             load_slot;
  logic             consumed;
  logic             s_bad;
  logic [W-1:0]     man_data;
  logic [W-1:0]     scan_data;
  logic [SEL_W-1:0] ch_ptr;
  logic             term;
  logic             scan_entry;
  logic             scan_capture;
  logic             counting;

  // A new sample may only be written when the output register is empty or
  // is being drained this cycle.
  assign load_slot = !out_valid || out_ready;
  assign consumed  = out_valid && out_ready;
  assign s_bad     = int'(s) >= N_CH;

  // Scan counter controls: restart on entry into scan, advance on every
  // scan capture, count only while dwelling below the terminal value.
  assign scan_entry   = en && mode && (state == IDLE || state == MANUAL);
  assign scan_capture = en && mode && load_slot &&
                        ((state == SCAN && term) || state == STALL);
  assign counting     = en && mode && (state == SCAN) && !term;

  // Channel selection; an out-of-range manual select matches no channel and
  // therefore yields zero.
  always_comb begin
    man_data  = '0;
    scan_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (s == SEL_W'(k)) man_data = w[k*W +: W];
      if (ch_ptr == SEL_W'(k)) scan_data = w[k*W +: W];
    end
  end

  scan_counter #(
    .N_CH  (N_CH),
    .DWELL (DWELL),
    .SEL_W (SEL_W)
  ) u_scan_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (scan_entry),
    .adv    (scan_capture),
    .hold   (!counting),
    .ch_ptr (ch_ptr),
    .term   (term)
  );

  // Controller and output register. Any cycle without a capture drains an
  // accepted sample; a capture overrides that because it reloads out_valid.
  // A mode change only switches state, so a pending sample survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      y         <= '0;
      ch        <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= 1'b0;
      if (consumed) out_valid <= 1'b0;
      if (!en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= mode ? SCAN : MANUAL;
          MANUAL: begin
            if (mode) begin
              state <= SCAN;
            end else if (load_slot) begin
              y         <= man_data;
              ch        <= s;
              out_valid <= 1'b1;
              sel_err   <= s_bad;
            end
          end
          SCAN, STALL: begin
            if (!mode) begin
              state <= MANUAL;
            end else if (scan_capture) begin
              y         <= scan_data;
              ch        <= ch_ptr;
              out_valid <= 1'b1;
              state     <= SCAN;
            end else if (state == SCAN && term) begin
              state <= STALL;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
